sub16_serial: RTL

- Nibble-serial 16-bit subtractor computing DIFF = INPUT1 - INPUT2 over WIDTH/SLICE clock cycles with one SLICE-bit slice.
- Produces the same status flags as the team's 16-bit adder: carry, sign, zero, parity and overflow.
- Sits in the datapath as the subtract counterpart to that adder; trades latency for area.
- Valid/ready handshake on both the operand side and the result side.

---
 rtl/sub16_serial.sv | 119 +++++++++++
 1 files changed

// File: rtl/sub16_serial.sv
// sub16_serial: slice-serial subtractor, diff = input1 - input2 (mod 2^WIDTH).
// One SLICE-bit slice per cycle, NSTEP = WIDTH/SLICE cycles per operation,
// with adder-compatible carry/sign/zero/parity/overflow flags and
// valid/ready handshakes on both sides.
module sub16_serial #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             carry,
  output logic             sign,
  output logic             zero,
  output logic             parity,
  output logic             overflow
);

  localparam int NSTEP = WIDTH / SLICE;
  localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam int MSB   = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q, b_q;   // operands latched on accept
  logic [WIDTH-1:0] acc_q;      // diff under construction, hidden from the port
  logic [SW-1:0]    step_q;
  logic             cy_q;       // running carry, 1 = no borrow so far

  logic [SLICE-1:0] a_sl, b_sl;
  logic [SLICE:0]   sum;
  logic [WIDTH-1:0] acc_nx;
  logic             last;
  logic             accept;

  // A new operation may start from IDLE, or from DONE while the result drains.
  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;

  // Current slice: A + ~B + carry, merged into the accumulated diff.
  always_comb begin
    a_sl   = a_q[step_q*SLICE +: SLICE];
    b_sl   = b_q[step_q*SLICE +: SLICE];
    sum    = {1'b0, a_sl} + {1'b0, ~b_sl} + {{SLICE{1'b0}}, cy_q};
    acc_nx = acc_q;
    acc_nx[step_q*SLICE +: SLICE] = sum[SLICE-1:0];
    last   = (step_q == SW'(NSTEP - 1));
  end

  // Control FSM with registered result; port diff/flags change only on CALC->DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      diff      <= '0;
      carry     <= 1'b0;
      sign      <= 1'b0;
      zero      <= 1'b0;
      parity    <= 1'b0;
      overflow  <= 1'b0;
      step_q    <= '0;
      cy_q      <= 1'b1;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q    <= input1;
            b_q    <= input2;
            step_q <= '0;
            cy_q   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          acc_q  <= acc_nx;
          cy_q   <= sum[SLICE];
          step_q <= step_q + SW'(1);
          if (last) begin
            state     <= DONE;
            out_valid <= 1'b1;
            diff      <= acc_nx;
            carry     <= sum[SLICE];
            sign      <= acc_nx[MSB];
            zero      <= (acc_nx == '0);
            parity    <= ~^acc_nx;
            overflow  <= (a_q[MSB] != b_q[MSB]) && (acc_nx[MSB] != a_q[MSB]);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              // back-to-back: result drains and new operands load on one edge
              a_q    <= input1;
              b_q    <= input2;
              step_q <= '0;
              cy_q   <= 1'b1;
              state  <= CALC;
            end else begin
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
